// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Branch resolution and prediction for the MIPS core pipeline. Holds the
//   architectural Z/N/C flag register, evaluates the eight branch condition
//   codes for the instruction in execute, and reports registered resolution
//   and misprediction results one cycle later. An optional table of 2-bit
//   saturating counters indexed by PC supplies a prediction to fetch.
//
//   Build option: define BRANCH_PREDICT_EN to build the counter table. When
//   it is undefined, no table is built and fetch always predicts not-taken.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   f_pc            fetch PC to predict
//   f_predict_taken combinational prediction for f_pc
//   ex_valid        execute slot holds a valid instruction
//   ex_branch       condition code (000 none, 001 JNZ, 010 JNN, 011 JNC,
//                   100 JMP, 101 JZ, 110 JN, 111 JC)
//   ex_pc           PC of the execute instruction
//   ex_predicted    prediction carried down the pipe with this instruction
//   flags_we        load z/n/c into the flag register this cycle
//   z, n, c         ALU flags produced this cycle
//   flags_q         flag register {z,n,c}
//   resolve_valid   registered: a branch was resolved last cycle
//   jump            registered: the resolved branch was taken
//   mispredict      registered: jump differs from ex_predicted
module branch_resolve_unit #(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_predict_taken,
    input  logic            ex_valid,
    input  logic [2:0]      ex_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_predicted,
    input  logic            flags_we,
    input  logic            z,
    input  logic            n,
    input  logic            c,
    output logic [2:0]      flags_q,
    output logic            resolve_valid,
    output logic            jump,
    output logic            mispredict
);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JNZ  = 3'b001,
        BR_JNN  = 3'b010,
        BR_JNC  = 3'b011,
        BR_JMP  = 3'b100,
        BR_JZ   = 3'b101,
        BR_JN   = 3'b110,
        BR_JC   = 3'b111
    } br_code_e;

    br_code_e   br_code;
    logic [2:0] eff_flags;
    logic       is_branch;
    logic       cond_taken;

    logic [2:0] flag_reg_d, flag_reg_q;
    logic       resolve_valid_d, resolve_valid_q;
    logic       jump_d, jump_q;
    logic       mispredict_d, mispredict_q;

    assign br_code = br_code_e'(ex_branch);

    always_comb begin
        // Same-cycle bypass: a flag write in this cycle is seen by the branch.
        eff_flags = flags_we ? {z, n, c} : flag_reg_q;
        is_branch = ex_valid && (br_code != BR_NONE);

        cond_taken = 1'b0;
        case (br_code)
            BR_JMP:  cond_taken = 1'b1;
            BR_JZ:   cond_taken = eff_flags[2];
            BR_JN:   cond_taken = eff_flags[1];
            BR_JC:   cond_taken = eff_flags[0];
            BR_JNZ:  cond_taken = !eff_flags[2];
            BR_JNN:  cond_taken = !eff_flags[1];
            BR_JNC:  cond_taken = !eff_flags[0];
            default: cond_taken = 1'b0;
        endcase

        flag_reg_d      = eff_flags;
        resolve_valid_d = is_branch;
        jump_d          = is_branch && cond_taken;
        mispredict_d    = is_branch && (cond_taken ^ ex_predicted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg_q      <= '0;
            resolve_valid_q <= 1'b0;
            jump_q          <= 1'b0;
            mispredict_q    <= 1'b0;
        end else begin
            flag_reg_q      <= flag_reg_d;
            resolve_valid_q <= resolve_valid_d;
            jump_q          <= jump_d;
            mispredict_q    <= mispredict_d;
        end
    end

    assign flags_q       = flag_reg_q;
    assign resolve_valid = resolve_valid_q;
    assign jump          = jump_q;
    assign mispredict    = mispredict_q;

`ifdef BRANCH_PREDICT_EN
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;

    // Word-aligned PCs: bits [1:0] never select a counter.
    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    always_comb begin
        for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (is_branch) begin
            if (cond_taken) begin
                if (bht_q[ex_idx] != 2'b11) begin
                    bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
                end
            end else if (bht_q[ex_idx] != 2'b00) begin
                bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Reads the registered table, so a same-cycle update is not bypassed.
    assign f_predict_taken = bht_q[f_idx][1];
`else
    assign f_predict_taken = 1'b0;
`endif

    // PC bits outside the index field (or all of them without the table).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc, ex_pc};

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction unit for the MIPS core pipeline. It holds the architectural Z/N/C flag register and evaluates eight branch condition codes (the four unconditional/positive codes plus their negations) for the instruction in execute. It keeps a table of 2-bit saturating counters indexed by PC, which supplies a taken/not-taken prediction to fetch. It reports registered resolution and misprediction results to the hazard/flush logic one cycle after execute.

## Interface

- PC_W, 16: width of PC inputs; must satisfy PC_W >= IDX_W+2.
- BHT_DEPTH, 16: number of prediction counters; power of two, 2..256.
- IDX_W, $clog2(BHT_DEPTH): derived index width; not to be overridden.

Ports (one clock; reset is synchronous and active-high):

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- f_pc  in  PC_W  fetch PC to predict.
- f_predict_taken  out  1  combinational prediction for f_pc.
- ex_valid  in  1  execute slot holds a valid instruction (enable).
- ex_branch  in  3  condition code: 000 none, 001 JNZ, 010 JNN, 011 JNC, 100 JMP, 101 JZ, 110 JN, 111 JC.
- ex_pc  in  PC_W  PC of the execute instruction.
- ex_predicted  in  1  prediction carried down the pipe with this instruction.
- flags_we  in  1  write z/n/c into the flag register this cycle.
- z, n, c  in  1 each  flags produced by the ALU this cycle.
- flags_q  out  3  flag register {z,n,c}.
- resolve_valid  out  1  registered: a branch was resolved last cycle.
- jump  out  1  registered: resolved branch taken.
- mispredict  out  1  registered: jump != ex_predicted of the resolved branch.

## Operation

- Branch instruction = ex_valid && ex_branch != 000. No other combination resolves or updates state.
- Effective flags: {z,n,c} inputs when flags_we=1, else flags_q (same-cycle bypass).
- Condition evaluation: 100 -> 1; 101 -> Z; 110 -> N; 111 -> C; 001 -> !Z; 010 -> !N; 011 -> !C.
- Flag register: loads {z,n,c} on every edge with flags_we=1, independent of ex_valid.
- Prediction table: BHT_DEPTH 2-bit counters; index = pc[IDX_W+1:2]. f_predict_taken = counter[f_idx][1].
- Table update on each branch instruction at index of ex_pc: taken -> increment, saturating at 11; not taken -> decrement, saturating at 00. JMP updates as taken.
- Same-index fetch read and execute update in the same cycle: the fetch read returns the pre-update value. No bypass.
- mispredict is computed against ex_predicted as supplied, not against the table contents.

## Timing

- Reset values: flags_q=000, resolve_valid=0, jump=0, mispredict=0, all counters=01 (weakly not-taken). As a result, f_predict_taken=0 everywhere after reset.
- rst has priority over every other input in the same cycle. Asserting rst mid-sequence discards the pending result: outputs read 0 on the next cycle.
- Latency: inputs sampled at edge k -> resolve_valid/jump/mispredict valid in cycle k+1.
  - Each result lasts exactly one cycle unless another branch resolves at edge k+1.
  - Back-to-back branches yield one result per cycle.
- When there is no branch instruction at edge k, resolve_valid, jump and mispredict are all 0 in cycle k+1.
- f_predict_taken is purely combinational from f_pc and the table state. A table update at edge k is visible to fetch from cycle k+1.

## Configuration

- BRANCH_PREDICT_EN defined: the counter table, indexing and updates are built as described above.
- BRANCH_PREDICT_EN undefined: no table storage is built.
  - f_predict_taken is tied to 0 (static not-taken).
  - mispredict still equals jump XOR ex_predicted, so a taken branch flags a mispredict when ex_predicted=0.
  - The flag register and resolution logic are unchanged.

## Test plan

- Reset, then ex_branch=101 with ex_valid=1, flags_we=0 -> next cycle resolve_valid=1, jump=0 (Z=0 after reset), mispredict=0.
- flags_we=1 with z=1 in the same cycle as JZ and ex_predicted=0 -> bypass gives jump=1, mispredict=1; flags_q=100 afterwards.
- Three consecutive taken JMPs at ex_pc=0x0010 -> counter at index 4 goes 01->10->11->11. f_predict_taken for f_pc=0x0010 is 1 from the cycle after the first update.
- JNC with flags_q c=1, ex_valid=0 -> resolve_valid=0, jump=0, table unchanged. Repeat with ex_valid=1 -> jump=0.
- Same-cycle f_pc=ex_pc=0x0020 with counter 01 and a taken update -> f_predict_taken=0 that cycle, 1 the next.
- rst asserted in the cycle after a taken branch is sampled -> jump=0 and resolve_valid=0; counter at that index back to 01.
